// File: rtl/sdf_pkg.sv
// sdf_pkg: shared sizing and scaling helpers for the R2SDF butterfly stage.
// Provides the default feedback depth, the output-width rule and the
// optional divide-by-two scaling applied to butterfly results.
package sdf_pkg;
    localparam int DEF_LOG2_DELAY = 2;
    function automatic int delay_of(input int log2_delay);
        return 1 << log2_delay;
    endfunction
    // Full growth keeps one extra bit; scaled output stays at input width.
    function automatic int ow_of(input int width, input int scale);
        return (scale != 0) ? width : width + 1;
    endfunction
    // Operates on a sign-extended 32-bit copy so any stage width can share it;
    // >>> gives floor division for negative values.
    function automatic logic signed [31:0] scale_val(input logic signed [31:0] v, input logic scale);
        return scale ? v >>> 1 : v;
    endfunction
endpackage

// File: rtl/sdf_delay_mem.sv
// sdf_delay_mem: feedback delay line, combinational read / synchronous write.
// Ports: clk clock; we write enable; addr shared read/write address;
//        wd write data; rd read data (old contents on a same-cycle write).
module sdf_delay_mem #(
    parameter int DEPTH_LOG2 = 2,
    parameter int DW = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DW-1:0]         wd,
    output logic [DW-1:0]         rd
);
    logic [DW-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    assign rd = mem[addr];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
    end
endmodule

// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 single-path delay-feedback FFT butterfly stage.
// Ports: clk clock; rst async active-high reset; in_valid/in_re/in_im input
//        sample; out_valid/out_sof/out_re/out_im registered output sample,
//        out_sof marking the first sum of each frame.
module sdf_r2_stage
    import sdf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2_DELAY = DEF_LOG2_DELAY,
    parameter int SCALE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic signed [WIDTH-1:0]              in_re,
    input  logic signed [WIDTH-1:0]              in_im,
    output logic                                 out_valid,
    output logic                                 out_sof,
    output logic signed [ow_of(WIDTH, SCALE)-1:0] out_re,
    output logic signed [ow_of(WIDTH, SCALE)-1:0] out_im
);
    localparam int D = delay_of(LOG2_DELAY);
    localparam int OW = ow_of(WIDTH, SCALE);
    localparam int IW = WIDTH + 1;
    localparam int CW = LOG2_DELAY + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(D);
    logic [CW-1:0] cnt;
    logic primed, phase, qual;
    logic [2*IW-1:0] m_rd;
    logic signed [IW-1:0] x_re, x_im, m_re, m_im, r_re, r_im, w_re, w_im;
    assign phase = cnt[LOG2_DELAY];
    assign x_re = IW'(in_re);
    assign x_im = IW'(in_im);
    assign m_re = m_rd[2*IW-1:IW];
    assign m_im = m_rd[IW-1:0];
    // First half of a frame emits the stored differences of the previous
    // frame; second half emits sums and stores differences in their place.
    assign r_re = phase ? m_re + x_re : m_re;
    assign r_im = phase ? m_im + x_im : m_im;
    assign w_re = phase ? m_re - x_re : x_re;
    assign w_im = phase ? m_im - x_im : x_im;
    // primed is already set by the first cnt>=D input, so it alone gates
    // out the unfilled memory of the first half-frame after reset.
    assign qual = in_valid & primed;
    sdf_delay_mem #(.DEPTH_LOG2(LOG2_DELAY), .DW(2*IW)) u_mem (
        .clk(clk),
        .we(in_valid),
        .addr(cnt[LOG2_DELAY-1:0]),
        .wd({w_re, w_im}),
        .rd(m_rd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            primed <= 1'b0;
            out_valid <= 1'b0;
            out_sof <= 1'b0;
            out_re <= '0;
            out_im <= '0;
        end else begin
            out_valid <= qual;
            out_sof <= qual && cnt == CNT_MID;
            if (in_valid) begin
                cnt <= cnt + CW'(1);
                if (cnt == CNT_LAST) primed <= 1'b1;
            end
            if (qual) begin
                out_re <= OW'(scale_val(32'(r_re), SCALE != 0));
                out_im <= OW'(scale_val(32'(r_im), SCALE != 0));
            end
        end
    end
endmodule

// File: tb/tb_sdf_r2_stage.sv
// tb_sdf_r2_stage: directed bench for sdf_r2_stage with a stream-level model.
module tb_sdf_r2_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic iv [3];
    logic signed [7:0] ire [3], iim [3];
    logic ov [3], osof [3];
    logic signed [8:0] r0, i0, r2, i2;
    logic signed [7:0] r1, i1;
    int o_re [3], o_im [3];
    int n_chk = 0, n_fail = 0;
    int dd [3] = '{4, 4, 8};
    int sc [3] = '{0, 1, 0};
    int xr [3][256], xi [3][256];
    int k [3] = '{0, 0, 0};
    int cyc = 0, c_in0 = 0, c_out0 = 0;
    bit first0 = 1'b1;
    int q0_re[$], q0_im[$], q0_sof[$], q1_re[$], q1_im[$], q2_sof[$];
    int q2_n = 0;

    always #5 clk = ~clk;

    sdf_r2_stage #(.WIDTH(8), .LOG2_DELAY(2), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_re(ire[0]), .in_im(iim[0]),
        .out_valid(ov[0]), .out_sof(osof[0]), .out_re(r0), .out_im(i0));
    sdf_r2_stage #(.WIDTH(8), .LOG2_DELAY(2), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_re(ire[1]), .in_im(iim[1]),
        .out_valid(ov[1]), .out_sof(osof[1]), .out_re(r1), .out_im(i1));
    sdf_r2_stage #(.WIDTH(8), .LOG2_DELAY(3), .SCALE(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_re(ire[2]), .in_im(iim[2]),
        .out_valid(ov[2]), .out_sof(osof[2]), .out_re(r2), .out_im(i2));

    always_comb begin
        o_re[0] = int'(r0);
        o_im[0] = int'(i0);
        o_re[1] = int'(r1);
        o_im[1] = int'(i1);
        o_re[2] = int'(r2);
        o_im[2] = int'(i2);
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int q[$], input int e[$]);
        chk({nm, "_len"}, q.size(), e.size());
        for (int j = 0; j < e.size() && j < q.size(); j++)
            chk($sformatf("%s[%0d]", nm, j), q[j], e[j]);
    endtask

    // Model: output j of the stream is butterfly element j of the input
    // stream, produced when valid input j+D arrives, visible one clock later.
    always @(posedge clk) begin
        bit r;
        bit ev [3], es [3];
        int er [3], ei [3];
        int j, b, m;
        r = rst;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0; es[i] = 1'b0; er[i] = 0; ei[i] = 0;
            if (r) k[i] = 0;
            else if (iv[i]) begin
                xr[i][k[i]] = int'(ire[i]);
                xi[i][k[i]] = int'(iim[i]);
                if (i == 0 && k[0] == 0) c_in0 = cyc;
                if (k[i] >= dd[i]) begin
                    j = k[i] - dd[i];
                    m = j % (2 * dd[i]);
                    b = j - m;
                    if (m < dd[i]) begin
                        er[i] = xr[i][b + m] + xr[i][b + m + dd[i]];
                        ei[i] = xi[i][b + m] + xi[i][b + m + dd[i]];
                    end else begin
                        er[i] = xr[i][b + m - dd[i]] - xr[i][b + m];
                        ei[i] = xi[i][b + m - dd[i]] - xi[i][b + m];
                    end
                    if (sc[i] != 0) begin
                        er[i] = er[i] >>> 1;
                        ei[i] = ei[i] >>> 1;
                    end
                    ev[i] = 1'b1;
                    es[i] = (m == 0);
                end
                k[i]++;
            end
        end
        if (r) first0 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_valid", i), int'(ov[i]), int'(ev[i]));
            chk($sformatf("d%0d_sof", i), int'(osof[i]), int'(es[i]));
            if (r || ev[i]) begin
                chk($sformatf("d%0d_re", i), o_re[i], er[i]);
                chk($sformatf("d%0d_im", i), o_im[i], ei[i]);
            end
        end
        if (ov[0]) begin
            q0_re.push_back(o_re[0]); q0_im.push_back(o_im[0]); q0_sof.push_back(int'(osof[0]));
            if (first0) begin c_out0 = cyc; first0 = 1'b0; end
        end
        if (ov[1]) begin q1_re.push_back(o_re[1]); q1_im.push_back(o_im[1]); end
        if (ov[2]) begin
            if (osof[2]) q2_sof.push_back(q2_n);
            q2_n++;
        end
    end

    task automatic put(input int i, input int re, input int im);
        @(negedge clk);
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        iv[i] = 1'b1;
        ire[i] = 8'(re);
        iim[i] = 8'(im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int j = 0; j < 3; j++) iv[j] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0_re.delete(); q0_im.delete(); q0_sof.delete();
        q1_re.delete(); q1_im.delete(); q2_sof.delete();
        q2_n = 0;
    endtask

    initial begin
        int e_re[$], e_im[$], e_sof[$];
        for (int j = 0; j < 3; j++) begin iv[j] = 1'b0; ire[j] = '0; iim[j] = '0; end
        e_sof = '{1, 0, 0, 0, 0, 0, 0, 0};
        // Ramp 1..8 then drain with zeros.
        do_reset();
        for (int n = 1; n <= 8; n++) put(0, n, 0);
        repeat (4) put(0, 0, 0);
        idle(3);
        e_re = '{6, 8, 10, 12, -4, -4, -4, -4};
        chk_q("t1_re", q0_re, e_re);
        chk_q("t1_sof", q0_sof, e_sof);
        chk("t1_latency", c_out0 - c_in0 + 1, 5);
        // Same ramp with a stall after every sample.
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            put(0, n <= 8 ? n : 0, 0);
            idle(1);
        end
        idle(2);
        chk_q("t2_re", q0_re, e_re);
        chk_q("t2_sof", q0_sof, e_sof);
        // Most negative inputs, full growth.
        do_reset();
        repeat (8) put(0, -128, -128);
        repeat (4) put(0, 0, 0);
        idle(2);
        e_re = '{-256, -256, -256, -256, 0, 0, 0, 0};
        chk_q("t3_re", q0_re, e_re);
        chk_q("t3_im", q0_im, e_re);
        // Scaled stage: positive extreme and floor rounding.
        do_reset();
        repeat (8) put(1, 127, 127);
        put(1, 3, 0);
        put(1, -3, 0);
        repeat (10) put(1, 0, 0);
        idle(2);
        e_re = '{127, 127, 127, 127, 0, 0, 0, 0, 1, -2, 0, 0, 1, -2, 0, 0};
        e_im = '{127, 127, 127, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_q("t4_re", q1_re, e_re);
        chk_q("t4_im", q1_im, e_im);
        // Three contiguous random frames on the D=8 stage.
        do_reset();
        repeat (48) put(2, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        repeat (8) put(2, 0, 0);
        idle(2);
        chk("t5_count", q2_n, 48);
        e_sof = '{0, 16, 32};
        chk_q("t5_sof_pos", q2_sof, e_sof);
        // Reset five samples into a frame, then restart.
        do_reset();
        for (int n = 9; n <= 16; n++) put(0, n, -n);
        for (int n = 50; n <= 54; n++) put(0, n, n);
        do_reset();
        for (int n = 1; n <= 8; n++) put(0, n, 0);
        repeat (4) put(0, 0, 0);
        idle(2);
        e_re = '{6, 8, 10, 12, -4, -4, -4, -4};
        e_sof = '{1, 0, 0, 0, 0, 0, 0, 0};
        chk_q("t6_re", q0_re, e_re);
        chk_q("t6_sof", q0_sof, e_sof);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
